soft_trig_sequencer: RTL and testbench

SOFT_TRIG_SEQUENCER -- requirements
Module: soft_trig_sequencer

---
 rtl/soft_trig_sequencer.sv | 149 ++++++++++++++
 tb/tb_soft_trig_sequencer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/soft_trig_sequencer.sv
// Software-started trigger burst sequencer: issues count_i one-cycle trigger pulses,
// spaced by delay_i clock-enable ticks, either broadcast or round-robin over a channel mask.
module soft_trig_sequencer #(
   parameter int NCHAN     = 4,
   parameter int CNT_WIDTH = 8,
   parameter int DLY_WIDTH = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 ce_i,
   input  logic                 go_i,
   input  logic                 abort_i,
   input  logic [CNT_WIDTH-1:0] count_i,
   input  logic [DLY_WIDTH-1:0] delay_i,
   input  logic [NCHAN-1:0]     mask_i,
   input  logic                 mode_i,
   output logic [NCHAN-1:0]     trig_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 ovf_o,
   output logic [CNT_WIDTH-1:0] sent_o
);

   localparam int PW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FIRE} state_t;

   state_t               state_q;
   logic [CNT_WIDTH-1:0] count_q;
   logic [DLY_WIDTH-1:0] delay_q;
   logic [DLY_WIDTH-1:0] cnt_q;
   logic [NCHAN-1:0]     mask_q;
   logic                 mode_q;
   logic [PW-1:0]        ptr_q;
   logic [CNT_WIDTH-1:0] sent_q;
   logic [CNT_WIDTH-1:0] sent_d;
   logic [NCHAN-1:0]     trig_q;
   logic [NCHAN-1:0]     fire_pat_d;
   logic                 busy_q;
   logic                 done_q;
   logic                 ovf_q;
   logic                 empty_q;   // an empty burst was accepted; done follows one edge later

   function automatic logic [PW-1:0] lowest_bit(input logic [NCHAN-1:0] m);
      lowest_bit = '0;
      for (int i = NCHAN - 1; i >= 0; i--) begin
         if (m[i]) lowest_bit = PW'(i);
      end
   endfunction

   // Next higher set mask bit above p, wrapping to the lowest set bit.
   function automatic logic [PW-1:0] next_bit(input logic [PW-1:0] p, input logic [NCHAN-1:0] m);
      logic found;
      next_bit = lowest_bit(m);
      found    = 1'b0;
      for (int i = 0; i < NCHAN; i++) begin
         if (!found && m[i] && (i > int'(p))) begin
            next_bit = PW'(i);
            found    = 1'b1;
         end
      end
   endfunction

   assign fire_pat_d = mode_q ? (NCHAN'(1) << ptr_q) : mask_q;
   assign sent_d     = sent_q + CNT_WIDTH'(1);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         count_q <= '0;
         delay_q <= '0;
         cnt_q   <= '0;
         mask_q  <= '0;
         mode_q  <= 1'b0;
         ptr_q   <= '0;
         sent_q  <= '0;
         trig_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         empty_q <= 1'b0;
      end else begin
         trig_q  <= '0;
         done_q  <= empty_q;
         empty_q <= 1'b0;
         if (go_i && state_q != S_IDLE) ovf_q <= 1'b1;

         case (state_q)
            S_IDLE: begin
               if (go_i && !abort_i) begin
                  count_q <= count_i;
                  delay_q <= delay_i;
                  mask_q  <= mask_i;
                  mode_q  <= mode_i;
                  ptr_q   <= lowest_bit(mask_i);
                  sent_q  <= '0;
                  cnt_q   <= '0;
                  ovf_q   <= 1'b0;
                  if (count_i == '0 || mask_i == '0) begin
                     empty_q <= 1'b1;
                  end else begin
                     state_q <= S_WAIT;
                     busy_q  <= 1'b1;
                  end
               end
            end
            S_WAIT: begin
               if (abort_i) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else if (cnt_q == delay_q) begin
                  state_q <= S_FIRE;
                  trig_q  <= fire_pat_d;
               end else if (ce_i) begin
                  cnt_q <= cnt_q + DLY_WIDTH'(1);
               end
            end
            S_FIRE: begin
               if (abort_i) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  sent_q <= sent_d;
                  ptr_q  <= next_bit(ptr_q, mask_q);
                  if (sent_d == count_q) begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_WAIT;
                     cnt_q   <= '0;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign trig_o = trig_q;
   assign busy_o = busy_q;
   assign done_o = done_q;
   assign ovf_o  = ovf_q;
   assign sent_o = sent_q;

endmodule

// File: tb/tb_soft_trig_sequencer.sv
// Directed bench for soft_trig_sequencer: cycle-by-cycle expected trig/done/busy tables per burst.
module tb_soft_trig_sequencer;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       ce_i;
   logic       go_i;
   logic       abort_i;
   logic [7:0] count_i;
   logic [15:0] delay_i;
   logic [3:0] mask_i;
   logic       mode_i;
   logic [3:0] trig_o;
   logic       busy_o;
   logic       done_o;
   logic       ovf_o;
   logic [7:0] sent_o;

   int checks   = 0;
   int failures = 0;

   logic [3:0] exp_trig [0:39];
   logic       exp_done [0:39];
   logic       exp_busy [0:39];

   soft_trig_sequencer #(.NCHAN(4), .CNT_WIDTH(8), .DLY_WIDTH(16)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .ce_i(ce_i), .go_i(go_i), .abort_i(abort_i),
      .count_i(count_i), .delay_i(delay_i), .mask_i(mask_i), .mode_i(mode_i),
      .trig_o(trig_o), .busy_o(busy_o), .done_o(done_o), .ovf_o(ovf_o), .sent_o(sent_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_tables();
      for (int i = 0; i < 40; i++) begin
         exp_trig[i] = 4'b0000;
         exp_done[i] = 1'b0;
         exp_busy[i] = 1'b0;
      end
   endtask

   task automatic set_busy(input int first, input int last);
      for (int i = first; i <= last; i++) exp_busy[i] = 1'b1;
   endtask

   // go_i in cycle 0 (accepted on the edge ending it); inputs scrambled from cycle 1 on.
   task automatic run_burst(input string name, input int ncyc, input int ce_div,
                            input int abort_cyc, input int go2_cyc);
      for (int c = 0; c < ncyc; c++) begin
         go_i    = (c == 0) || (c == go2_cyc);
         abort_i = (c == abort_cyc);
         ce_i    = (c % ce_div) == 0;
         if (c == 1) begin
            mask_i  = ~mask_i;
            count_i = count_i + 8'd1;
            delay_i = 16'd0;
            mode_i  = ~mode_i;
         end
         chk($sformatf("%s trig c%0d", name, c), 32'(trig_o), 32'(exp_trig[c]));
         chk($sformatf("%s done c%0d", name, c), 32'(done_o), 32'(exp_done[c]));
         chk($sformatf("%s busy c%0d", name, c), 32'(busy_o), 32'(exp_busy[c]));
         tick();
      end
      go_i    = 1'b0;
      abort_i = 1'b0;
      ce_i    = 1'b1;
      $display("burst %s complete: sent=%0d ovf=%0b", name, sent_o, ovf_o);
   endtask

   initial begin
      rst_i = 1'b1; ce_i = 1'b1; go_i = 1'b0; abort_i = 1'b0;
      count_i = '0; delay_i = '0; mask_i = '0; mode_i = 1'b0;
      #2;
      chk("reset trig", 32'(trig_o), 32'h0);
      chk("reset busy", 32'(busy_o), 32'h0);
      chk("reset done", 32'(done_o), 32'h0);
      chk("reset ovf",  32'(ovf_o),  32'h0);
      chk("reset sent", 32'(sent_o), 32'h0);
      tick();
      rst_i = 1'b0;
      tick();

      // Broadcast 1010, count 3, delay 2; extra go in cycle 6 sets overflow only.
      clear_tables();
      exp_trig[4] = 4'b1010; exp_trig[8] = 4'b1010; exp_trig[12] = 4'b1010;
      exp_done[13] = 1'b1;
      set_busy(1, 12);
      count_i = 8'd3; delay_i = 16'd2; mask_i = 4'b1010; mode_i = 1'b0;
      run_burst("bcast", 16, 1, -1, 6);
      chk("bcast sent", 32'(sent_o), 32'd3);
      chk("bcast ovf",  32'(ovf_o),  32'd1);

      // Round-robin over 1101, count 5, delay 0.
      clear_tables();
      exp_trig[2] = 4'b0001; exp_trig[4] = 4'b0100; exp_trig[6] = 4'b1000;
      exp_trig[8] = 4'b0001; exp_trig[10] = 4'b0100;
      exp_done[11] = 1'b1;
      set_busy(1, 10);
      count_i = 8'd5; delay_i = 16'd0; mask_i = 4'b1101; mode_i = 1'b1;
      run_burst("rr", 14, 1, -1, -1);
      chk("rr sent", 32'(sent_o), 32'd5);
      chk("rr ovf cleared", 32'(ovf_o), 32'd0);

      // ce_i one cycle in four, delay 3, count 2.
      clear_tables();
      exp_trig[14] = 4'b0011; exp_trig[26] = 4'b0011;
      exp_done[27] = 1'b1;
      set_busy(1, 26);
      count_i = 8'd2; delay_i = 16'd3; mask_i = 4'b0011; mode_i = 1'b0;
      run_burst("ce4", 30, 4, -1, -1);
      chk("ce4 sent", 32'(sent_o), 32'd2);

      // Empty burst: count 0.
      clear_tables();
      exp_done[2] = 1'b1;
      count_i = 8'd0; delay_i = 16'd1; mask_i = 4'b1111; mode_i = 1'b0;
      run_burst("cnt0", 5, 1, -1, -1);
      chk("cnt0 sent", 32'(sent_o), 32'd0);

      // Abort on the edge where the second trigger would fire.
      clear_tables();
      exp_trig[4] = 4'b1010;
      set_busy(1, 7);
      count_i = 8'd4; delay_i = 16'd2; mask_i = 4'b1010; mode_i = 1'b0;
      run_burst("abort", 14, 1, 7, -1);
      chk("abort sent", 32'(sent_o), 32'd1);

      // Reset during a trigger pulse clears everything immediately.
      count_i = 8'd3; delay_i = 16'd2; mask_i = 4'b0110; mode_i = 1'b0;
      go_i = 1'b1;
      tick();
      go_i = 1'b0;
      for (int c = 1; c < 4; c++) tick();
      chk("pre-rst trig", 32'(trig_o), 32'h6);
      rst_i = 1'b1;
      #1;
      chk("rst trig", 32'(trig_o), 32'h0);
      chk("rst busy", 32'(busy_o), 32'h0);
      chk("rst sent", 32'(sent_o), 32'h0);
      tick();
      rst_i = 1'b0;
      for (int c = 0; c < 8; c++) begin
         chk($sformatf("post-rst trig c%0d", c), 32'(trig_o), 32'h0);
         tick();
      end
      chk("post-rst busy", 32'(busy_o), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
